iob_pfsm_timed: RTL

//  Programmable FSM with per-transition dwell timing. A register-based LUT indexed by
//  {current_state, inputs} returns {dwell, next_state, outputs}. The FSM re-evaluates

---
 rtl/iob_pfsm_timed.sv | 98 +++++++++
 1 files changed

// File: rtl/iob_pfsm_timed.sv
// Programmable FSM: LUT indexed by {state, inputs} yields {dwell, next_state, outputs};
// re-evaluates when dwell expires. Define IOB_PFSM_TIMED_INPUT_SYNC_EN for a 2-flop input synchroniser.
module iob_pfsm_timed #(
    parameter int STATE_W  = 2,
    parameter int INPUT_W  = 1,
    parameter int OUTPUT_W = 4,
    parameter int CNT_W    = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   cke_i,
    input  logic                                   run_i,
    input  logic                                   restart_i,
    input  logic                                   lut_wen_i,
    input  logic [STATE_W+INPUT_W-1:0]             lut_waddr_i,
    input  logic [CNT_W+STATE_W+OUTPUT_W-1:0]      lut_wdata_i,
    input  logic [INPUT_W-1:0]                     input_ports_i,
    output logic [OUTPUT_W-1:0]                    output_ports_o,
    output logic [STATE_W-1:0]                     current_state_o,
    output logic [CNT_W-1:0]                       dwell_o,
    output logic                                   done_o,
    output logic                                   err_o
);

    localparam int ADDR_W = STATE_W + INPUT_W;
    localparam int LUT_W  = CNT_W + STATE_W + OUTPUT_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [STATE_W-1:0] TERMINAL = '1;

    logic [LUT_W-1:0]    lut_mem [DEPTH];
    logic [LUT_W-1:0]    lut_rdata;
    logic [INPUT_W-1:0]  in_eff;
    logic [STATE_W-1:0]  state_q;
    logic [CNT_W-1:0]    dwell_q;
    logic [OUTPUT_W-1:0] out_q;
    logic                err_q;

`ifdef IOB_PFSM_TIMED_INPUT_SYNC_EN
    logic [INPUT_W-1:0] sync1_q;
    logic [INPUT_W-1:0] sync2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else if (cke_i) begin
            sync1_q <= input_ports_i;
            sync2_q <= sync1_q;
        end
    end

    assign in_eff = sync2_q;
`else
    assign in_eff = input_ports_i;
`endif

    // LUT storage is deliberately not reset; the control layer programs it before run.
    always_ff @(posedge clk_i) begin
        if (lut_wen_i && cke_i && !run_i) begin
            lut_mem[lut_waddr_i] <= lut_wdata_i;
        end
    end

    always_comb begin
        lut_rdata = lut_mem[{state_q, in_eff}];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= '0;
            dwell_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            err_q <= lut_wen_i & run_i;
            if (restart_i) begin
                state_q <= '0;
                dwell_q <= '0;
                out_q   <= '0;
            end else if (run_i && state_q != TERMINAL) begin
                if (dwell_q != '0) begin
                    dwell_q <= dwell_q - CNT_W'(1);
                end else begin
                    dwell_q <= lut_rdata[LUT_W-1 -: CNT_W];
                    state_q <= lut_rdata[OUTPUT_W +: STATE_W];
                    out_q   <= lut_rdata[OUTPUT_W-1:0];
                end
            end
        end
    end

    assign output_ports_o  = out_q;
    assign current_state_o = state_q;
    assign dwell_o         = dwell_q;
    assign done_o          = (state_q == TERMINAL);
    assign err_o           = err_q;

endmodule
